ucie_ctl_sb_pkt_serializer: RTL and testbench
=============================================

Name: ucie_ctl_sb_pkt_serializer

Overview:
- Multi-source sideband packet builder and serializer for the UCIe controller SB transmit path.
- Round-robin arbitrates among NUM_SRC message requesters and latches the winning request.
- Builds a 64-bit header (phase0/phase1) with control and data parity, plus an optional 64-bit payload (phase2/phase3).
- Streams the packet as PHASE_W-bit beats over a valid/ready interface toward the SB link.

Parameters:
- PHASE_W, 32, output beat width; legal values 16, 32, 64 (must divide 64).
- NUM_SRC, 2, number of requesters; range 1..8.
- SRCID, 3'b001, source ID placed in phase0[31:29].
- DSTID, 3'b101, destination ID placed in phase1[26:24].

Ports:
- i_clk, in, 1, clock.
- i_rst, in, 1, reset: asynchronous, active-low.
- i_req_vld, in, NUM_SRC, per-source request valid.
- o_req_rdy, out, NUM_SRC, per-source accept; vld&rdy on source i = handshake.
- i_req_opcode, in, 5*NUM_SRC, opcode; source i occupies [5i+:5].
- i_req_msgcode, in, 8*NUM_SRC, message code.
- i_req_subcode, in, 8*NUM_SRC, message subcode.
- i_req_info, in, 16*NUM_SRC, MsgInfo field.
- i_req_has_data, in, NUM_SRC, 1 = packet carries 64-bit payload.
- i_req_data, in, 64*NUM_SRC, payload.
- o_phase_data, out, PHASE_W, current beat.
- o_phase_vld, out, 1, beat valid.
- i_phase_rdy, in, 1, downstream accepts beat.
- o_phase_sop, out, 1, first beat of packet.
- o_phase_eop, out, 1, last beat of packet.
- o_busy, out, 1, state != IDLE.

Behaviour:
- Header format:
  - phase0 = {SRCID, 7'b0, msgcode, 9'b0, opcode}.
  - phase1 = {dp, cp, 3'b0, DSTID, info, subcode}.
  - cp = XOR of phase0[31:0] and phase1[29:0].
  - dp = XOR of data[63:0] when has_data, else 0.
  - H = {phase1, phase0}; D = data.
- Beats:
  - B = 64/PHASE_W beats per word.
  - Beat k of a word = word[k*PHASE_W +: PHASE_W]; H first, then D if has_data.
  - Packet length = B or 2B beats.
- FSM states: IDLE, HDR, DATA.
  - IDLE: grant = first requesting source at or after rr_ptr (wrapping). o_req_rdy = grant one-hot, combinational, IDLE only, zero when no vld.
  - On handshake: latch fields, compute parity, beat_cnt <= 0, rr_ptr <= (grant+1) mod NUM_SRC, go to HDR.
  - HDR: o_phase_vld = 1. On i_phase_rdy, increment beat_cnt. On the last beat (beat_cnt = B-1) with rdy, go to DATA and clear beat_cnt if has_data, else go to IDLE.
  - DATA: same rules; last beat with rdy -> IDLE.
- sop = (HDR & beat_cnt == 0); eop = last beat of packet.
- Stall: while vld & !rdy, o_phase_data, sop and eop are held stable.
- Request inputs are sampled only at handshake; later changes do not affect the packet in flight.
- Back-to-back packets: one IDLE bubble cycle between packets. Minimum latency from handshake to first beat is 1 cycle.
- Idle output: o_phase_data = 0 whenever o_phase_vld = 0.
- Simultaneous requests: only the granted source sees rdy; the others hold vld and are served in round-robin order, so no source starves.
- PHASE_W = 64: B = 1; sop and eop are both high on a header-only packet.
- Reset (async, including mid-packet): state = IDLE, rr_ptr = 0, beat_cnt = 0, latched fields = 0. All outputs = 0; the partial packet is abandoned with no eop.
- Illegal PHASE_W or NUM_SRC is rejected by an elaboration-time check.

Decomposition:
- Package ucie_ctl_sb_pkg holds:
  - field widths (OP 5, MSG 8, SUB 8, INFO 16);
  - default SRCID/DSTID;
  - FSM state encoding;
  - header-build and parity functions.
- Sub-module ucie_ctl_sb_rr_arbiter, parameterised by NUM_SRC: inputs req and ptr, outputs one-hot grant and encoded index.

Test Plan:
- PHASE_W=32. src0 opcode 0x12, msgcode 0x01, sub 0, info 0, no data, rdy=1 -> beats 0x20004012 (sop) then 0x05000000 (eop); cp=0, dp=0.
- PHASE_W=32. src0 opcode 0x1B, msgcode 0x02, data 0x00000001_00000003 -> beats 0x2000801B, 0x85000000, 0x00000003, 0x00000001; eop on the 4th beat.
- src0 and src1 request continuously -> grants alternate 0,1,0,1; rr_ptr wraps; each accept is a single-cycle rdy pulse.
- Hold i_phase_rdy=0 for 5 cycles on beat 1 -> data, sop and eop stable; the packet resumes with no lost or duplicated beat.
- PHASE_W=16, data packet -> 8 beats, low half-word first; PHASE_W=64, no data -> 1 beat with sop=eop=1.
- Assert i_rst low during a DATA beat -> all outputs go to 0 asynchronously. After release, a new request starts with sop and rr_ptr=0.

Source files
------------

// File: rtl/ucie_ctl_sb_pkg.sv
// ---------------------------------------------------------------------------
// ucie_ctl_sb_pkg
// Shared definitions for the UCIe controller sideband transmit path:
//   - message field widths (opcode, msgcode, subcode, MsgInfo)
//   - default source / destination IDs
//   - serializer FSM state encoding
//   - header build and parity helper functions
// ---------------------------------------------------------------------------
package ucie_ctl_sb_pkg;

  localparam int OP_W   = 5;
  localparam int MSG_W  = 8;
  localparam int SUB_W  = 8;
  localparam int INFO_W = 16;

  localparam logic [2:0] SRCID_DEF = 3'b001;
  localparam logic [2:0] DSTID_DEF = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } sb_state_e;

  // Data parity is forced to zero on header-only packets even if the
  // requester leaves junk on its data bus.
  function automatic logic calc_dp(input logic [63:0] data, input logic has_data);
    return has_data & (^data);
  endfunction

  // Control parity covers all of phase0 and phase1 except the two parity bits.
  function automatic logic calc_cp(input logic [31:0] p0, input logic [29:0] p1_low);
    return ^{p0, p1_low};
  endfunction

  // Returns H = {phase1, phase0}.
  function automatic logic [63:0] build_header(
    input logic [2:0]        srcid,
    input logic [2:0]        dstid,
    input logic [OP_W-1:0]   opcode,
    input logic [MSG_W-1:0]  msgcode,
    input logic [SUB_W-1:0]  subcode,
    input logic [INFO_W-1:0] info,
    input logic [63:0]       data,
    input logic              has_data
  );
    logic [31:0] p0;
    logic [31:0] p1;
    p0     = {srcid, 7'b0, msgcode, 9'b0, opcode};
    p1     = {2'b00, 3'b000, dstid, info, subcode};
    p1[31] = calc_dp(data, has_data);
    p1[30] = calc_cp(p0, p1[29:0]);
    return {p1, p0};
  endfunction

endpackage

// File: rtl/ucie_ctl_sb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ucie_ctl_sb_rr_arbiter
// Combinational round-robin pick: the first requesting source at or after
// i_ptr, wrapping around to source 0.
//   i_req   : per-source request
//   i_ptr   : index with highest priority this cycle
//   o_grant : one-hot grant (zero when nothing requests)
//   o_idx   : encoded grant index (zero when nothing requests)
// ---------------------------------------------------------------------------
module ucie_ctl_sb_rr_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int IDXW    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [IDXW-1:0]    i_ptr,
  output logic [NUM_SRC-1:0] o_grant,
  output logic [IDXW-1:0]    o_idx
);

  logic w_found;

  // Two passes avoid a modulo: sources at/after the pointer first, then the
  // wrapped-around sources below it.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (!w_found && i_req[j] && (j >= int'(i_ptr))) begin
        w_found    = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = IDXW'(j);
      end
    end
    for (int j = 0; j < NUM_SRC; j++) begin
      if (!w_found && i_req[j] && (j < int'(i_ptr))) begin
        w_found    = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/ucie_ctl_sb_pkt_serializer.sv
// ---------------------------------------------------------------------------
// ucie_ctl_sb_pkt_serializer
// Sideband packet builder/serializer. Arbitrates round-robin among NUM_SRC
// requesters, latches the winner, builds the 64-bit header with control and
// data parity, and streams header (and optional 64-bit payload) as
// PHASE_W-bit beats, low bits first.
//   i_clk, i_rst              : clock, async active-low reset
//   i_req_* / o_req_rdy       : per-source request, accept on vld & rdy
//   o_phase_data/vld/sop/eop  : beat stream toward the SB link
//   i_phase_rdy               : downstream accepts current beat
//   o_busy                    : packet in flight
//
// state   | meaning
// ST_IDLE | no packet in flight; arbitrate, accept one request
// ST_HDR  | streaming header beats
// ST_DATA | streaming payload beats
// ---------------------------------------------------------------------------
module ucie_ctl_sb_pkt_serializer
  import ucie_ctl_sb_pkg::*;
#(
  parameter int         PHASE_W = 32,
  parameter int         NUM_SRC = 2,
  parameter logic [2:0] SRCID   = SRCID_DEF,
  parameter logic [2:0] DSTID   = DSTID_DEF
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_SRC-1:0]         i_req_vld,
  output logic [NUM_SRC-1:0]         o_req_rdy,
  input  logic [OP_W*NUM_SRC-1:0]    i_req_opcode,
  input  logic [MSG_W*NUM_SRC-1:0]   i_req_msgcode,
  input  logic [SUB_W*NUM_SRC-1:0]   i_req_subcode,
  input  logic [INFO_W*NUM_SRC-1:0]  i_req_info,
  input  logic [NUM_SRC-1:0]         i_req_has_data,
  input  logic [64*NUM_SRC-1:0]      i_req_data,
  output logic [PHASE_W-1:0]         o_phase_data,
  output logic                       o_phase_vld,
  input  logic                       i_phase_rdy,
  output logic                       o_phase_sop,
  output logic                       o_phase_eop,
  output logic                       o_busy
);

  localparam int B    = 64 / PHASE_W;
  localparam int BCW  = (B > 1) ? $clog2(B) : 1;
  localparam int IDXW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [BCW-1:0] LAST = BCW'(B - 1);

  if (!(PHASE_W == 16 || PHASE_W == 32 || PHASE_W == 64)) begin : g_bad_phase_w
    $error("ucie_ctl_sb_pkt_serializer: PHASE_W must be 16, 32 or 64");
  end
  if (NUM_SRC < 1 || NUM_SRC > 8) begin : g_bad_num_src
    $error("ucie_ctl_sb_pkt_serializer: NUM_SRC must be 1..8");
  end

  sb_state_e           r_state;
  logic [BCW-1:0]      r_beat_cnt;
  logic [IDXW-1:0]     r_rr_ptr;
  logic [63:0]         r_hdr;
  logic [63:0]         r_data;
  logic                r_has_data;
  logic [PHASE_W-1:0]  r_phase_data;
  logic                r_phase_vld;
  logic                r_phase_sop;
  logic                r_phase_eop;

  logic [NUM_SRC-1:0]  w_grant;
  logic [IDXW-1:0]     w_gidx;
  logic [IDXW-1:0]     w_next_ptr;
  logic                w_idle;
  logic                w_hs;
  logic                w_last;
  logic [BCW-1:0]      w_cnt_inc;
  logic [OP_W-1:0]     w_sel_opcode;
  logic [MSG_W-1:0]    w_sel_msgcode;
  logic [SUB_W-1:0]    w_sel_subcode;
  logic [INFO_W-1:0]   w_sel_info;
  logic                w_sel_has_data;
  logic [63:0]         w_sel_data;
  logic [63:0]         w_new_hdr;

  function automatic logic [PHASE_W-1:0] f_beat(input logic [63:0] word, input logic [BCW-1:0] k);
    return word[int'(k)*PHASE_W +: PHASE_W];
  endfunction

  ucie_ctl_sb_rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .IDXW    (IDXW)
  ) u_arb (
    .i_req   (i_req_vld),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx)
  );

  assign w_idle = (r_state == ST_IDLE);
  assign w_hs   = w_idle && (|i_req_vld);

  // Gated by reset so every output reads zero while i_rst is asserted.
  assign o_req_rdy = (w_idle && i_rst) ? w_grant : '0;

  assign w_next_ptr = (w_gidx == IDXW'(NUM_SRC - 1)) ? '0 : w_gidx + 1'b1;

  assign w_sel_opcode   = i_req_opcode  [int'(w_gidx)*OP_W   +: OP_W];
  assign w_sel_msgcode  = i_req_msgcode [int'(w_gidx)*MSG_W  +: MSG_W];
  assign w_sel_subcode  = i_req_subcode [int'(w_gidx)*SUB_W  +: SUB_W];
  assign w_sel_info     = i_req_info    [int'(w_gidx)*INFO_W +: INFO_W];
  assign w_sel_has_data = i_req_has_data[w_gidx];
  assign w_sel_data     = i_req_data    [int'(w_gidx)*64     +: 64];

  assign w_new_hdr = build_header(SRCID, DSTID, w_sel_opcode, w_sel_msgcode,
                                  w_sel_subcode, w_sel_info, w_sel_data,
                                  w_sel_has_data);

  assign w_last    = (r_beat_cnt == LAST);
  assign w_cnt_inc = r_beat_cnt + 1'b1;

  // Beat outputs are registered: each transition loads the beat that will be
  // presented next, so a stalled beat simply keeps its register contents.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= ST_IDLE;
      r_beat_cnt   <= '0;
      r_rr_ptr     <= '0;
      r_hdr        <= '0;
      r_data       <= '0;
      r_has_data   <= 1'b0;
      r_phase_data <= '0;
      r_phase_vld  <= 1'b0;
      r_phase_sop  <= 1'b0;
      r_phase_eop  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_hdr        <= w_new_hdr;
            r_data       <= w_sel_data;
            r_has_data   <= w_sel_has_data;
            r_rr_ptr     <= w_next_ptr;
            r_beat_cnt   <= '0;
            r_state      <= ST_HDR;
            r_phase_vld  <= 1'b1;
            r_phase_data <= w_new_hdr[PHASE_W-1:0];
            r_phase_sop  <= 1'b1;
            r_phase_eop  <= (B == 1) && !w_sel_has_data;
          end
        end
        ST_HDR: begin
          if (i_phase_rdy) begin
            r_phase_sop <= 1'b0;
            if (w_last) begin
              r_beat_cnt <= '0;
              if (r_has_data) begin
                r_state      <= ST_DATA;
                r_phase_data <= r_data[PHASE_W-1:0];
                r_phase_eop  <= (B == 1);
              end else begin
                r_state      <= ST_IDLE;
                r_phase_vld  <= 1'b0;
                r_phase_data <= '0;
                r_phase_eop  <= 1'b0;
              end
            end else begin
              r_beat_cnt   <= w_cnt_inc;
              r_phase_data <= f_beat(r_hdr, w_cnt_inc);
              r_phase_eop  <= (w_cnt_inc == LAST) && !r_has_data;
            end
          end
        end
        ST_DATA: begin
          if (i_phase_rdy) begin
            r_phase_sop <= 1'b0;
            if (w_last) begin
              r_beat_cnt   <= '0;
              r_state      <= ST_IDLE;
              r_phase_vld  <= 1'b0;
              r_phase_data <= '0;
              r_phase_eop  <= 1'b0;
            end else begin
              r_beat_cnt   <= w_cnt_inc;
              r_phase_data <= f_beat(r_data, w_cnt_inc);
              r_phase_eop  <= (w_cnt_inc == LAST);
            end
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_beat_cnt   <= '0;
          r_phase_vld  <= 1'b0;
          r_phase_data <= '0;
          r_phase_sop  <= 1'b0;
          r_phase_eop  <= 1'b0;
        end
      endcase
    end
  end

  assign o_phase_data = r_phase_data;
  assign o_phase_vld  = r_phase_vld;
  assign o_phase_sop  = r_phase_sop;
  assign o_phase_eop  = r_phase_eop;
  assign o_busy       = !w_idle;

endmodule

// File: tb/tb_ucie_ctl_sb_pkt_serializer.sv
module tb_ucie_ctl_sb_pkt_serializer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Shared request buses (2 sources); separate vld/rdy per DUT instance.
  logic [9:0]   opc;
  logic [15:0]  msg;
  logic [15:0]  sub;
  logic [31:0]  info;
  logic [1:0]   hd;
  logic [127:0] data;

  logic [1:0] vld32, vld16, vld64;
  logic [1:0] rrdy32, rrdy16, rrdy64;
  logic       prdy32, prdy16, prdy64;
  logic [31:0] d32;
  logic [15:0] d16;
  logic [63:0] d64;
  logic pv32, pv16, pv64, sop32, sop16, sop64, eop32, eop16, eop64, bz32, bz16, bz64;

  ucie_ctl_sb_pkt_serializer #(.PHASE_W(32), .NUM_SRC(2)) u_dut32 (
    .i_clk(clk), .i_rst(rst), .i_req_vld(vld32), .o_req_rdy(rrdy32),
    .i_req_opcode(opc), .i_req_msgcode(msg), .i_req_subcode(sub), .i_req_info(info),
    .i_req_has_data(hd), .i_req_data(data), .o_phase_data(d32), .o_phase_vld(pv32),
    .i_phase_rdy(prdy32), .o_phase_sop(sop32), .o_phase_eop(eop32), .o_busy(bz32));

  ucie_ctl_sb_pkt_serializer #(.PHASE_W(16), .NUM_SRC(2)) u_dut16 (
    .i_clk(clk), .i_rst(rst), .i_req_vld(vld16), .o_req_rdy(rrdy16),
    .i_req_opcode(opc), .i_req_msgcode(msg), .i_req_subcode(sub), .i_req_info(info),
    .i_req_has_data(hd), .i_req_data(data), .o_phase_data(d16), .o_phase_vld(pv16),
    .i_phase_rdy(prdy16), .o_phase_sop(sop16), .o_phase_eop(eop16), .o_busy(bz16));

  ucie_ctl_sb_pkt_serializer #(.PHASE_W(64), .NUM_SRC(2)) u_dut64 (
    .i_clk(clk), .i_rst(rst), .i_req_vld(vld64), .o_req_rdy(rrdy64),
    .i_req_opcode(opc), .i_req_msgcode(msg), .i_req_subcode(sub), .i_req_info(info),
    .i_req_has_data(hd), .i_req_data(data), .o_phase_data(d64), .o_phase_vld(pv64),
    .i_phase_rdy(prdy64), .o_phase_sop(sop64), .o_phase_eop(eop64), .o_busy(bz64));

  typedef struct {
    int          dut;       // 0: PHASE_W=32, 1: 16, 2: 64
    logic [4:0]  op;
    logic [7:0]  msgc;
    logic [7:0]  subc;
    logic [15:0] inf;
    logic        hasd;
    logic [63:0] dat;
    int          nb;
    logic [63:0] beats [8];
    int          stall_at;  // beat index held with rdy=0 for 5 cycles, -1 none
  } vec_t;

  vec_t tbl [10];
  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] f_data(input int d);
    case (d)
      0:       return 64'(d32);
      1:       return 64'(d16);
      default: return d64;
    endcase
  endfunction
  function automatic logic f_vld(input int d);
    return (d == 0) ? pv32 : (d == 1) ? pv16 : pv64;
  endfunction
  function automatic logic f_sop(input int d);
    return (d == 0) ? sop32 : (d == 1) ? sop16 : sop64;
  endfunction
  function automatic logic f_eop(input int d);
    return (d == 0) ? eop32 : (d == 1) ? eop16 : eop64;
  endfunction
  function automatic logic f_busy(input int d);
    return (d == 0) ? bz32 : (d == 1) ? bz16 : bz64;
  endfunction
  function automatic logic [1:0] f_rrdy(input int d);
    return (d == 0) ? rrdy32 : (d == 1) ? rrdy16 : rrdy64;
  endfunction

  task automatic set_vld(input int d, input logic [1:0] v);
    if (d == 0) vld32 = v; else if (d == 1) vld16 = v; else vld64 = v;
  endtask
  task automatic set_prdy(input int d, input logic r);
    if (d == 0) prdy32 = r; else if (d == 1) prdy16 = r; else prdy64 = r;
  endtask

  task automatic load_src(input int s, input logic [4:0] o, input logic [7:0] m,
                          input logic [7:0] sb, input logic [15:0] inf,
                          input logic h, input logic [63:0] dt);
    opc[s*5 +: 5]   = o;
    msg[s*8 +: 8]   = m;
    sub[s*8 +: 8]   = sb;
    info[s*16 +: 16] = inf;
    hd[s]           = h;
    data[s*64 +: 64] = dt;
  endtask

  task automatic out_zero(input string tag, input int d);
    chk({tag, "_vld"},  64'(f_vld(d)),  64'd0);
    chk({tag, "_data"}, f_data(d),      64'd0);
    chk({tag, "_sop"},  64'(f_sop(d)),  64'd0);
    chk({tag, "_eop"},  64'(f_eop(d)),  64'd0);
    chk({tag, "_busy"}, 64'(f_busy(d)), 64'd0);
    chk({tag, "_rrdy"}, 64'(f_rrdy(d)), 64'd0);
  endtask

  task automatic wait_rrdy(input string tag, input int d, input logic [1:0] exp);
    int w;
    w = 0;
    @(negedge clk);
    while (f_rrdy(d) == 2'b00 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_req_rdy"}, 64'(f_rrdy(d)), 64'(exp));
  endtask

  task automatic check_beat(input string tag, input int d, input logic [63:0] b,
                            input logic s, input logic e);
    chk({tag, "_vld"},  64'(f_vld(d)), 64'd1);
    chk({tag, "_data"}, f_data(d),     b);
    chk({tag, "_sop"},  64'(f_sop(d)), 64'(s));
    chk({tag, "_eop"},  64'(f_eop(d)), 64'(e));
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    string tag;
    v = tbl[vi];
    @(posedge clk); #1;
    load_src(0, v.op, v.msgc, v.subc, v.inf, v.hasd, v.dat);
    set_prdy(v.dut, 1'b1);
    set_vld(v.dut, 2'b01);
    wait_rrdy($sformatf("v%0d", vi), v.dut, 2'b01);
    @(posedge clk); #1;
    set_vld(v.dut, 2'b00);
    // Scramble source 0 after the handshake; the packet must not change.
    load_src(0, 5'h1F, 8'hFF, 8'hFF, 16'hFFFF, ~v.hasd, ~v.dat);
    for (int k = 0; k < v.nb; k++) begin
      @(negedge clk);
      tag = $sformatf("v%0d_b%0d", vi, k);
      check_beat(tag, v.dut, v.beats[k], k == 0, k == v.nb - 1);
      if (k == v.stall_at) begin
        set_prdy(v.dut, 1'b0);
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          check_beat($sformatf("%s_stall%0d", tag, s), v.dut, v.beats[k], k == 0, k == v.nb - 1);
        end
        set_prdy(v.dut, 1'b1);
      end
    end
    @(negedge clk);
    tag = $sformatf("v%0d_idle", vi);
    chk({tag, "_vld"},  64'(f_vld(v.dut)),  64'd0);
    chk({tag, "_data"}, f_data(v.dut),      64'd0);
    chk({tag, "_busy"}, 64'(f_busy(v.dut)), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_p0 [2];
    int g_n, last_cyc, pend, w;

    //        dut op     msg    sub    info      hd data                     nb beats                                                                                stall
    tbl[0] = '{0, 5'h12, 8'h01, 8'h00, 16'h0000, 0, 64'h0,                   2, '{64'h20004012, 64'h05000000, 0, 0, 0, 0, 0, 0}, -1};
    tbl[1] = '{0, 5'h1B, 8'h02, 8'h00, 16'h0000, 1, 64'h00000001_00000003,  4, '{64'h2000801B, 64'h85000000, 64'h3, 64'h1, 0, 0, 0, 0}, -1};
    tbl[2] = '{0, 5'h01, 8'h00, 8'h01, 16'h0000, 0, 64'h0,                   2, '{64'h20000001, 64'h45000001, 0, 0, 0, 0, 0, 0}, -1};
    tbl[3] = '{0, 5'h1F, 8'hFF, 8'hA5, 16'h1234, 1, 64'hFFFFFFFF_00000000,  4, '{64'h203FC01F, 64'h451234A5, 64'h0, 64'hFFFFFFFF, 0, 0, 0, 0}, -1};
    tbl[4] = '{0, 5'h00, 8'h80, 8'h00, 16'h8001, 1, 64'h00000000_00000007,  4, '{64'h20200000, 64'h85800100, 64'h7, 64'h0, 0, 0, 0, 0}, -1};
    tbl[5] = '{0, 5'h05, 8'h10, 8'h0C, 16'h0000, 0, 64'hDEADBEEF_00000001,  2, '{64'h20040005, 64'h0500000C, 0, 0, 0, 0, 0, 0}, -1};
    tbl[6] = '{0, 5'h1B, 8'h02, 8'h00, 16'h0000, 1, 64'h00000001_00000003,  4, '{64'h2000801B, 64'h85000000, 64'h3, 64'h1, 0, 0, 0, 0}, 1};
    tbl[7] = '{1, 5'h1B, 8'h02, 8'h00, 16'h0000, 1, 64'h00000001_00000003,  8, '{64'h801B, 64'h2000, 64'h0000, 64'h8500, 64'h0003, 64'h0000, 64'h0001, 64'h0000}, -1};
    tbl[8] = '{2, 5'h12, 8'h01, 8'h00, 16'h0000, 0, 64'h0,                   1, '{64'h05000000_20004012, 0, 0, 0, 0, 0, 0, 0}, -1};
    tbl[9] = '{2, 5'h1B, 8'h02, 8'h00, 16'h0000, 1, 64'h00000001_00000003,  2, '{64'h85000000_2000801B, 64'h00000001_00000003, 0, 0, 0, 0, 0, 0}, -1};

    opc = '0; msg = '0; sub = '0; info = '0; hd = '0; data = '0;
    vld32 = '0; vld16 = '0; vld64 = '0;
    prdy32 = 1'b1; prdy16 = 1'b1; prdy64 = 1'b1;

    // Reset state
    #3;
    for (int d = 0; d < 3; d++) out_zero($sformatf("rst_d%0d", d), d);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Directed packet table
    for (int i = 0; i < 10; i++) run_vec(i);

    // Round robin: both sources request continuously on the 32-bit DUT
    do_reset();
    load_src(0, 5'h12, 8'h01, 8'h00, 16'h0000, 1'b0, 64'h0);
    load_src(1, 5'h01, 8'h00, 8'h01, 16'h0000, 1'b0, 64'h0);
    exp_p0[0] = 64'h20004012;
    exp_p0[1] = 64'h20000001;
    prdy32 = 1'b1;
    @(posedge clk); #1;
    vld32 = 2'b11;
    g_n = 0; last_cyc = -1; pend = -1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (pend >= 0) begin
        chk($sformatf("rr_beat%0d_data", g_n), f_data(0), exp_p0[pend]);
        chk($sformatf("rr_beat%0d_sop", g_n), 64'(sop32), 64'd1);
        pend = -1;
      end
      if (rrdy32 != 2'b00) begin
        chk($sformatf("rr_grant%0d", g_n), 64'(rrdy32), 64'(2'b01 << (g_n % 2)));
        if (g_n > 0) chk($sformatf("rr_gap%0d", g_n), 64'(cyc - last_cyc), 64'd3);
        last_cyc = cyc;
        pend = g_n % 2;
        g_n++;
      end
    end
    chk("rr_grant_count", 64'(g_n), 64'd4);
    vld32 = 2'b00;
    w = 0;
    while (bz32 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("rr_drain_busy", 64'(bz32), 64'd0);

    // Reset asserted during a DATA beat
    @(posedge clk); #1;
    load_src(0, 5'h1B, 8'h02, 8'h00, 16'h0000, 1'b1, 64'h00000001_00000003);
    vld32 = 2'b01;
    wait_rrdy("mr", 0, 2'b01);
    @(posedge clk); #1;
    vld32 = 2'b00;
    repeat (3) @(negedge clk);
    chk("mr_pre_data", f_data(0), 64'h3);
    #2;
    rst = 1'b0;
    #1;
    out_zero("mr_async", 0);
    @(negedge clk);
    rst = 1'b1;
    load_src(1, 5'h01, 8'h00, 8'h01, 16'h0000, 1'b0, 64'h0);
    @(posedge clk); #1;
    vld32 = 2'b11;
    @(negedge clk);
    chk("mr_post_grant", 64'(rrdy32), 64'h1);
    @(posedge clk); #1;
    vld32 = 2'b00;
    @(negedge clk);
    check_beat("mr_post_b0", 0, 64'h2000801B, 1'b1, 1'b0);
    w = 0;
    while (bz32 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("mr_drain_busy", 64'(bz32), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
